// File: rtl/stepper_step_driver.sv
// Converts the reg_24 target and reg_25 period taps into step/dir/enable pulses
// for the JA stepper header, and tracks the absolute motor position in steps.
module stepper_step_driver #(
  parameter int POS_WIDTH    = 16,
  parameter int PER_WIDTH    = 24,
  parameter int MIN_PERIOD   = 1000,
  parameter int PULSE_CYCLES = 200,
  parameter int DIR_SETUP    = 100,
  parameter int POS_MIN      = -2000,
  parameter int POS_MAX      = 2000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          target_in,
  input  logic [31:0]          period_in,
  input  logic                 motor_en,
  input  logic                 zero_pos,
  output logic                 step,
  output logic                 dir,
  output logic                 en_n,
  output logic [POS_WIDTH-1:0] position,
  output logic                 busy,
  output logic                 at_target
);

  localparam int FLOOR_PER = (MIN_PERIOD > PULSE_CYCLES + 1) ? MIN_PERIOD : PULSE_CYCLES + 1;

  localparam logic [PER_WIDTH-1:0]        C_FLOOR_PER = PER_WIDTH'(FLOOR_PER);
  localparam logic [PER_WIDTH-1:0]        C_SETUP_LD  = PER_WIDTH'(DIR_SETUP - 1);
  localparam logic [PER_WIDTH-1:0]        C_PULSE_LD  = PER_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [PER_WIDTH-1:0]        C_LOW_SUB   = PER_WIDTH'(PULSE_CYCLES + 1);
  localparam logic signed [POS_WIDTH-1:0] C_POS_MIN   = POS_WIDTH'(POS_MIN);
  localparam logic signed [POS_WIDTH-1:0] C_POS_MAX   = POS_WIDTH'(POS_MAX);
  localparam logic signed [POS_WIDTH-1:0] C_ONE       = POS_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  state_t r_state, w_state_nxt;
  state_t w_dec_state;

  logic signed [POS_WIDTH-1:0] w_tgt_raw;
  logic signed [POS_WIDTH-1:0] w_tgt_clamp;
  logic signed [POS_WIDTH-1:0] r_target_q;
  logic signed [POS_WIDTH-1:0] r_position;
  logic signed [POS_WIDTH-1:0] w_pos_nxt;

  logic [PER_WIDTH-1:0] w_per_raw;
  logic [PER_WIDTH-1:0] w_eff_per;
  logic [PER_WIDTH-1:0] r_eff_per;
  logic [PER_WIDTH-1:0] w_eff_nxt;
  logic [PER_WIDTH-1:0] w_dec_eff;
  logic [PER_WIDTH-1:0] r_cnt;
  logic [PER_WIDTH-1:0] w_cnt_nxt;
  logic [PER_WIDTH-1:0] w_dec_cnt;

  logic r_dir, w_dir_nxt, w_dec_dir;
  logic w_want_move, w_need_dir;
  logic r_step, r_en_n, r_busy, r_at_target;
  logic w_unused;

  assign w_unused = ^{target_in[31:POS_WIDTH], period_in[31:PER_WIDTH]};

  assign w_tgt_raw = signed'(target_in[POS_WIDTH-1:0]);
  assign w_per_raw = period_in[PER_WIDTH-1:0];

  always_comb begin
    w_tgt_clamp = w_tgt_raw;
    if (w_tgt_raw < C_POS_MIN) begin
      w_tgt_clamp = C_POS_MIN;
    end else if (w_tgt_raw > C_POS_MAX) begin
      w_tgt_clamp = C_POS_MAX;
    end
  end

  assign w_eff_per = (w_per_raw > C_FLOOR_PER) ? w_per_raw : C_FLOOR_PER;

  // Shared step-boundary decision, used from IDLE and from the last LOW cycle.
  always_comb begin
    w_want_move = motor_en && (r_target_q != r_position);
    w_need_dir  = (r_target_q > r_position);
    w_dec_state = S_IDLE;
    w_dec_cnt   = r_cnt;
    w_dec_dir   = r_dir;
    w_dec_eff   = r_eff_per;
    if (w_want_move) begin
      if (w_need_dir != r_dir) begin
        w_dec_state = S_SETUP;
        w_dec_dir   = w_need_dir;
        w_dec_cnt   = C_SETUP_LD;
      end else begin
        w_dec_state = S_HIGH;
        w_dec_cnt   = C_PULSE_LD;
        w_dec_eff   = w_eff_per;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_pos_nxt   = r_position;
    w_eff_nxt   = r_eff_per;
    case (r_state)
      S_IDLE: begin
        if (zero_pos) begin
          w_pos_nxt = '0;
        end else begin
          w_state_nxt = w_dec_state;
          w_cnt_nxt   = w_dec_cnt;
          w_dir_nxt   = w_dec_dir;
          w_eff_nxt   = w_dec_eff;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = C_PULSE_LD;
          w_eff_nxt   = w_eff_per;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HIGH: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = r_eff_per - C_LOW_SUB;
          w_pos_nxt   = r_dir ? (r_position + C_ONE) : (r_position - C_ONE);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_LOW: begin
        if (r_cnt == '0) begin
          w_state_nxt = w_dec_state;
          w_cnt_nxt   = w_dec_cnt;
          w_dir_nxt   = w_dec_dir;
          w_eff_nxt   = w_dec_eff;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output flags are registered from next-state values so they line up with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_eff_per   <= '0;
      r_dir       <= 1'b0;
      r_position  <= '0;
      r_target_q  <= '0;
      r_step      <= 1'b0;
      r_en_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_at_target <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_eff_per   <= w_eff_nxt;
      r_dir       <= w_dir_nxt;
      r_position  <= w_pos_nxt;
      r_target_q  <= w_tgt_clamp;
      r_step      <= (w_state_nxt == S_HIGH);
      r_en_n      <= !(motor_en || (w_state_nxt != S_IDLE));
      r_busy      <= (w_state_nxt != S_IDLE);
      r_at_target <= (w_state_nxt == S_IDLE) && (w_pos_nxt == w_tgt_clamp);
    end
  end

  assign step      = r_step;
  assign dir       = r_dir;
  assign en_n      = r_en_n;
  assign position  = r_position;
  assign busy      = r_busy;
  assign at_target = r_at_target;

endmodule

// File: tb/tb_stepper_step_driver.sv
// Bench for stepper_step_driver: table vectors, directed corner sequences and
// random stimulus checked every clock against a timestamp-based reference model.
module tb_stepper_step_driver;

  localparam int P    = 2;
  localparam int S    = 3;
  localparam int MINP = 8;
  localparam int PMIN = -20;
  localparam int PMAX = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] target_in = '0;
  logic [31:0] period_in = '0;
  logic        motor_en = 1'b0;
  logic        zero_pos = 1'b0;
  logic        step, dir, en_n, busy, at_target;
  logic [15:0] position;

  stepper_step_driver #(
    .POS_WIDTH(16), .PER_WIDTH(24), .MIN_PERIOD(MINP), .PULSE_CYCLES(P),
    .DIR_SETUP(S), .POS_MIN(PMIN), .POS_MAX(PMAX)
  ) dut (
    .clock(clock), .reset(reset), .target_in(target_in), .period_in(period_in),
    .motor_en(motor_en), .zero_pos(zero_pos), .step(step), .dir(dir),
    .en_n(en_n), .position(position), .busy(busy), .at_target(at_target)
  );

  always #5 clock = ~clock;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint last_rise = -1, prev_rise = -1;
  logic   prev_step = 1'b0;

  // Model: phase 0 idle, 1 waiting out dir setup, 2 in a step that rose at m_rise.
  int     m_tq = 0, m_pos = 0, m_eff = MINP, m_phase = 0;
  logic   m_dir = 1'b0;
  longint m_rise = 0;
  logic   m_step = 1'b0, m_busy = 1'b0, m_en_n = 1'b1, m_at = 1'b1;

  function automatic int clamp_t(logic [31:0] t);
    int v;
    v = int'($signed(t[15:0]));
    if (v < PMIN) v = PMIN;
    if (v > PMAX) v = PMAX;
    return v;
  endfunction

  function automatic int eff_of(logic [31:0] p);
    int v;
    v = int'(p[23:0]);
    if (v < MINP) v = MINP;
    if (v < P + 1) v = P + 1;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic decide(longint n);
    if (!(motor_en && (m_tq != m_pos))) begin
      m_phase = 0;
    end else if ((m_tq > m_pos) != m_dir) begin
      m_dir   = (m_tq > m_pos);
      m_phase = 1;
      m_rise  = n + S;
    end else begin
      m_phase = 2;
      m_rise  = n;
      m_eff   = eff_of(period_in);
    end
  endtask

  task automatic model_edge(longint n);
    int tq_new;
    tq_new = clamp_t(target_in);
    if (reset) begin
      m_tq = 0; m_pos = 0; m_dir = 1'b0; m_phase = 0;
      m_step = 1'b0; m_busy = 1'b0; m_en_n = 1'b1; m_at = 1'b1;
      return;
    end
    case (m_phase)
      0: if (zero_pos) m_pos = 0; else decide(n);
      1: if (n == m_rise) begin m_phase = 2; m_eff = eff_of(period_in); end
      default: begin
        if (n == m_rise + P) m_pos += m_dir ? 1 : -1;
        else if (n == m_rise + m_eff) decide(n);
      end
    endcase
    m_tq   = tq_new;
    m_step = (m_phase == 2) && (n < m_rise + P);
    m_busy = (m_phase != 0);
    m_en_n = !(motor_en || m_busy);
    m_at   = (m_phase == 0) && (m_pos == m_tq);
  endtask

  task automatic tick();
    cyc++;
    model_edge(cyc);
    @(posedge clock);
    #1;
    if (step && !prev_step) begin
      prev_rise = last_rise;
      last_rise = cyc;
    end
    prev_step = step;
    check("step", int'(step), int'(m_step));
    check("dir", int'(dir), int'(m_dir));
    check("en_n", int'(en_n), int'(m_en_n));
    check("busy", int'(busy), int'(m_busy));
    check("at_target", int'(at_target), int'(m_at));
    check("position", int'($signed(position)), m_pos);
  endtask

  typedef struct {
    logic rst; int tgt; int per; logic en; logic zp; int cycles;
    int e_pos; logic e_dir; logic e_busy; logic e_at; logic e_en_n;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int k;
    int p0;
    tbl[0] = '{1'b1,   0,  0, 1'b0, 1'b0,   3,  0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0,   3, 10, 1'b1, 1'b0,  40,  3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0,  -2,  4, 1'b1, 1'b0,  50, -2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 100,  8, 1'b1, 1'b0, 200, 20, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0,   0,  8, 1'b0, 1'b0,   5, 20, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0,   0,  8, 1'b0, 1'b1,   3,  0, 1'b1, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 6; i++) begin
      reset     = tbl[i].rst;
      target_in = 32'(tbl[i].tgt);
      period_in = 32'(tbl[i].per);
      motor_en  = tbl[i].en;
      zero_pos  = tbl[i].zp;
      repeat (tbl[i].cycles) tick();
      check($sformatf("tbl%0d.pos", i), int'($signed(position)), tbl[i].e_pos);
      check($sformatf("tbl%0d.dir", i), int'(dir), int'(tbl[i].e_dir));
      check($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].e_busy));
      check($sformatf("tbl%0d.at_target", i), int'(at_target), int'(tbl[i].e_at));
      check($sformatf("tbl%0d.en_n", i), int'(en_n), int'(tbl[i].e_en_n));
    end
    zero_pos = 1'b0;

    // Retarget mid-HIGH: pulse completes, then reversal after setup.
    target_in = 32'd10; period_in = 32'd8; motor_en = 1'b1;
    k = 0;
    while (!($signed(position) == 16'sd5 && step) && k < 200) begin tick(); k++; end
    check("wait_pos5_high", int'($signed(position) == 16'sd5 && step), 1);
    check("rise_spacing", int'(last_rise - prev_rise), 8);
    target_in = 32'd4;
    k = 0;
    while ($signed(position) != 16'sd6 && k < 20) begin tick(); k++; end
    check("pulse_completes_pos6", int'($signed(position)), 6);
    k = 0;
    while (dir && k < 20) begin tick(); k++; end
    check("dir_reversed", int'(dir), 0);
    k = 0;
    while (!step && k < 10) begin tick(); k++; end
    check("setup_len", k, S);
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    check("retarget_final_pos", int'($signed(position)), 4);

    // Drop motor_en mid-step; zero_pos while busy is ignored, honoured in IDLE.
    target_in = -32'sd10; motor_en = 1'b1;
    k = 0;
    while (!step && k < 50) begin tick(); k++; end
    check("wait_step_b", int'(step), 1);
    p0 = int'($signed(position));
    motor_en = 1'b0; zero_pos = 1'b1;
    tick();
    zero_pos = 1'b0;
    check("zero_ignored_busy", int'($signed(position)), p0);
    check("still_busy", int'(busy), 1);
    k = 0;
    while (busy && k < 20) begin tick(); k++; end
    check("drop_en_pos", int'($signed(position)), p0 - 1);
    check("drop_en_en_n", int'(en_n), 1);
    zero_pos = 1'b1;
    tick();
    zero_pos = 1'b0;
    check("zero_in_idle", int'($signed(position)), 0);

    // Reset during HIGH aborts with no further position change.
    target_in = 32'd10; motor_en = 1'b1;
    k = 0;
    while (!step && k < 50) begin tick(); k++; end
    check("wait_step_c", int'(step), 1);
    reset = 1'b1;
    tick();
    check("rst_step", int'(step), 0);
    check("rst_pos", int'($signed(position)), 0);
    check("rst_en_n", int'(en_n), 1);
    reset = 1'b0; motor_en = 1'b0;
    repeat (5) tick();
    check("rst_no_incr", int'($signed(position)), 0);

    // Random stimulus against the model.
    for (int r = 0; r < 250; r++) begin
      reset    = ($urandom_range(59) == 0);
      zero_pos = ($urandom_range(7) == 0);
      motor_en = ($urandom_range(7) != 0);
      if ($urandom_range(9) == 0) target_in = $urandom();
      else target_in = 32'($signed($urandom_range(60)) - 30);
      period_in = {8'($urandom()), 24'($urandom_range(14))};
      repeat ($urandom_range(1, 30)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
